// File: rtl/mcpu_core_icache_arb_pkg.sv
// Shared core definitions for the I$ lookup-port arbiter: requester IDs and
// the fetch/I$ address width.
package mcpu_core_icache_arb_pkg;

  localparam int unsigned ADDR_W = 28;

  typedef logic arb_id_t;

  localparam arb_id_t ARB_ID_F = 1'b0;
  localparam arb_id_t ARB_ID_P = 1'b1;

endpackage

// File: rtl/mcpu_core_icache_arb_if.sv
// Bus bundle between fetch, secondary requester, I$ and the arbiter.
// The master view is the arbiter; the slave view is everything around it.
interface mcpu_core_icache_arb_if;
  import mcpu_core_icache_arb_pkg::*;

  logic [ADDR_W-1:0] f2arb_vaddr;
  logic              f2arb_valid;
  logic              arb2f_gnt;
  logic              arb2f_rsp_valid;
  logic [ADDR_W-1:0] p2arb_vaddr;
  logic              p2arb_valid;
  logic              arb2p_gnt;
  logic              arb2p_rsp_valid;
  logic [ADDR_W-1:0] arb_rsp_paddr;
  logic              pipe_flush;
  logic [ADDR_W-1:0] arb2ic_vaddr;
  logic              arb2ic_valid;
  logic              ic2arb_ready;
  logic [ADDR_W-1:0] ic2arb_paddr;

  modport master (
    input  f2arb_vaddr, f2arb_valid, p2arb_vaddr, p2arb_valid,
    input  pipe_flush, ic2arb_ready, ic2arb_paddr,
    output arb2f_gnt, arb2f_rsp_valid, arb2p_gnt, arb2p_rsp_valid,
    output arb_rsp_paddr, arb2ic_vaddr, arb2ic_valid
  );

  modport slave (
    output f2arb_vaddr, f2arb_valid, p2arb_vaddr, p2arb_valid,
    output pipe_flush, ic2arb_ready, ic2arb_paddr,
    input  arb2f_gnt, arb2f_rsp_valid, arb2p_gnt, arb2p_rsp_valid,
    input  arb_rsp_paddr, arb2ic_vaddr, arb2ic_valid
  );

endinterface

// File: rtl/mcpu_core_arb_starve.sv
// Saturating count of consecutive denied secondary-request cycles; raises
// p_prio for one grant once the count reaches STARVE_MAX.
module mcpu_core_arb_starve #(
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned CNT_W      = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic p_valid,
  input  logic p_gnt,
  output logic p_prio
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             p_prio_q, p_prio_d;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    p_prio_d     = p_prio_q;
    if (p_gnt || !p_valid) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != MAX_C) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
    // Look at the next count so priority applies on the very next cycle.
    if (p_gnt) begin
      p_prio_d = 1'b0;
    end else if (starve_cnt_d == MAX_C) begin
      p_prio_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      p_prio_q     <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      p_prio_q     <= p_prio_d;
    end
  end

  assign p_prio = p_prio_q;

endmodule

// File: rtl/mcpu_core_icache_arb.sv
// Arbiter for the single I$ lookup port: fetch has priority, the secondary
// requester is protected from starvation, and flushed fetch responses are dropped.
module mcpu_core_icache_arb
  import mcpu_core_icache_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned CNT_W      = 4
) (
  input  logic                  clkrst_core_clk,
  input  logic                  clkrst_core_rst_n,
  mcpu_core_icache_arb_if.master bus
);

  logic    inflight_q, inflight_d;
  arb_id_t owner_q, owner_d;
  logic    drop_q, drop_d;
  logic    p_prio;
  arb_id_t sel;
  logic    req, accept, gnt_f, gnt_p, kill_f;

  always_comb begin
    if (p_prio && bus.p2arb_valid) begin
      sel = ARB_ID_P;
    end else if (bus.f2arb_valid) begin
      sel = ARB_ID_F;
    end else begin
      sel = ARB_ID_P;
    end
  end

  // Outputs are forced low while reset is held, combinational paths included.
  assign req    = (bus.f2arb_valid | bus.p2arb_valid) & clkrst_core_rst_n;
  assign accept = req & bus.ic2arb_ready;
  assign gnt_f  = accept & (sel == ARB_ID_F);
  assign gnt_p  = accept & (sel == ARB_ID_P);
  assign kill_f = drop_q | bus.pipe_flush;

  assign bus.arb2ic_valid    = req;
  assign bus.arb2ic_vaddr    = !clkrst_core_rst_n ? '0 :
                               (sel == ARB_ID_P) ? bus.p2arb_vaddr : bus.f2arb_vaddr;
  assign bus.arb2f_gnt       = gnt_f;
  assign bus.arb2p_gnt       = gnt_p;
  assign bus.arb2f_rsp_valid = clkrst_core_rst_n & inflight_q & bus.ic2arb_ready &
                               (owner_q == ARB_ID_F) & !kill_f;
  assign bus.arb2p_rsp_valid = clkrst_core_rst_n & inflight_q & bus.ic2arb_ready &
                               (owner_q == ARB_ID_P);
  assign bus.arb_rsp_paddr   = clkrst_core_rst_n ? bus.ic2arb_paddr : '0;

  always_comb begin
    inflight_d = inflight_q;
    owner_d    = owner_q;
    drop_d     = drop_q;
    if (accept) begin
      inflight_d = 1'b1;
      owner_d    = sel;
      drop_d     = 1'b0;
    end else if (bus.ic2arb_ready) begin
      inflight_d = 1'b0;
    end else if (bus.pipe_flush && inflight_q && (owner_q == ARB_ID_F)) begin
      drop_d = 1'b1;
    end
  end

  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      inflight_q <= 1'b0;
      owner_q    <= ARB_ID_F;
      drop_q     <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      owner_q    <= owner_d;
      drop_q     <= drop_d;
    end
  end

  mcpu_core_arb_starve #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_starve (
    .clk     (clkrst_core_clk),
    .rst_n   (clkrst_core_rst_n),
    .p_valid (bus.p2arb_valid),
    .p_gnt   (gnt_p),
    .p_prio  (p_prio)
  );

endmodule

// File: tb/tb_mcpu_core_icache_arb.sv
// Directed bench for the I$ lookup-port arbiter.
module tb_mcpu_core_icache_arb;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mcpu_core_icache_arb_if ifc ();

  mcpu_core_icache_arb #(.STARVE_MAX(8), .CNT_W(4)) dut (
    .clkrst_core_clk   (clk),
    .clkrst_core_rst_n (rst_n),
    .bus               (ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Status vector: {arb2ic_valid, gnt_F, gnt_P, rsp_F, rsp_P}
  function automatic logic [4:0] status();
    return {ifc.arb2ic_valid, ifc.arb2f_gnt, ifc.arb2p_gnt,
            ifc.arb2f_rsp_valid, ifc.arb2p_rsp_valid};
  endfunction

  // Apply one cycle of inputs at the falling edge; outputs settle 1 time unit later.
  task automatic drive(input logic fv, input logic [27:0] fa, input logic pv,
                       input logic [27:0] pa, input logic rdy, input logic [27:0] ipa,
                       input logic fl);
    @(negedge clk);
    ifc.f2arb_valid  = fv;
    ifc.f2arb_vaddr  = fa;
    ifc.p2arb_valid  = pv;
    ifc.p2arb_vaddr  = pa;
    ifc.ic2arb_ready = rdy;
    ifc.ic2arb_paddr = ipa;
    ifc.pipe_flush   = fl;
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] st;
    rst_n = 1'b0;
    drive(1'b1, 28'h0000010, 1'b1, 28'h0000020, 1'b1, 28'h1234567, 1'b0);
    st = status();
    checks++;
    if (st !== 5'b00000) begin
      errors++;
      $display("FAIL reset_status got %b exp %b", st, 5'b00000);
    end
    checks++;
    if (ifc.arb2ic_vaddr !== 28'h0 || ifc.arb_rsp_paddr !== 28'h0) begin
      errors++;
      $display("FAIL reset_addr got vaddr %h paddr %h exp 0 0", ifc.arb2ic_vaddr, ifc.arb_rsp_paddr);
    end
    drive(1'b0, 28'h0, 1'b0, 28'h0, 1'b0, 28'h0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_fetch_only();
    logic [27:0] va [4]  = '{28'h0000010, 28'h0000011, 28'h0000012, 28'h0};
    logic [27:0] pa [4]  = '{28'h0, 28'h1000010, 28'h1000011, 28'h1000012};
    logic [4:0]  exp [4] = '{5'b11000, 5'b11010, 5'b11010, 5'b00010};
    logic [4:0]  st;
    for (int i = 0; i < 4; i++) begin
      drive(i < 3, va[i], 1'b0, 28'h0, 1'b1, pa[i], 1'b0);
      st = status();
      checks++;
      if (st !== exp[i]) begin
        errors++;
        $display("FAIL fetch_status[%0d] got %b exp %b", i, st, exp[i]);
      end
      if (i < 3) begin
        checks++;
        if (ifc.arb2ic_vaddr !== va[i]) begin
          errors++;
          $display("FAIL fetch_vaddr[%0d] got %h exp %h", i, ifc.arb2ic_vaddr, va[i]);
        end
      end
      if (i > 0) begin
        checks++;
        if (ifc.arb_rsp_paddr !== pa[i]) begin
          errors++;
          $display("FAIL fetch_paddr[%0d] got %h exp %h", i, ifc.arb_rsp_paddr, pa[i]);
        end
      end
    end
    drive(1'b0, 28'h0, 1'b0, 28'h0, 1'b1, 28'h0, 1'b0);
    st = status();
    checks++;
    if (st !== 5'b00000) begin
      errors++;
      $display("FAIL fetch_idle got %b exp %b", st, 5'b00000);
    end
  endtask

  task automatic test_starvation();
    logic        sel_p, prev_p;
    logic [27:0] exp_va;
    logic [4:0]  exp, st;
    prev_p = 1'b0;
    for (int i = 0; i < 18; i++) begin
      sel_p  = (i == 8) || (i == 17);
      exp_va = sel_p ? 28'h0ABCDEF : 28'h0000100 + 28'(i);
      exp    = {1'b1, !sel_p, sel_p, (i > 0) && !prev_p, (i > 0) && prev_p};
      drive(1'b1, 28'h0000100 + 28'(i), 1'b1, 28'h0ABCDEF, 1'b1, 28'h0, 1'b0);
      st = status();
      checks++;
      if (st !== exp) begin
        errors++;
        $display("FAIL starve_status[%0d] got %b exp %b", i, st, exp);
      end
      checks++;
      if (ifc.arb2ic_vaddr !== exp_va) begin
        errors++;
        $display("FAIL starve_vaddr[%0d] got %h exp %h", i, ifc.arb2ic_vaddr, exp_va);
      end
      prev_p = sel_p;
    end
    drive(1'b0, 28'h0, 1'b0, 28'h0, 1'b1, 28'h0, 1'b0);
    st = status();
    checks++;
    if (st !== 5'b00001) begin
      errors++;
      $display("FAIL starve_drain got %b exp %b", st, 5'b00001);
    end
  endtask

  task automatic test_flush_drop();
    logic [4:0] st;
    drive(1'b1, 28'h0000020, 1'b0, 28'h0, 1'b1, 28'h0, 1'b0);
    st = status();
    checks++;
    if (st !== 5'b11000) begin
      errors++;
      $display("FAIL flush_grant got %b exp %b", st, 5'b11000);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 28'h0, 1'b0, 28'h0, 1'b0, 28'h0, i == 0);
      st = status();
      checks++;
      if (st !== 5'b00000) begin
        errors++;
        $display("FAIL flush_wait[%0d] got %b exp %b", i, st, 5'b00000);
      end
    end
    drive(1'b0, 28'h0, 1'b0, 28'h0, 1'b1, 28'h0005555, 1'b0);
    st = status();
    checks++;
    if (st !== 5'b00000) begin
      errors++;
      $display("FAIL flush_dropped got %b exp %b", st, 5'b00000);
    end
    drive(1'b1, 28'h0000030, 1'b0, 28'h0, 1'b1, 28'h0, 1'b0);
    st = status();
    checks++;
    if (st !== 5'b11000) begin
      errors++;
      $display("FAIL flush_next_grant got %b exp %b", st, 5'b11000);
    end
    drive(1'b0, 28'h0, 1'b0, 28'h0, 1'b1, 28'h000030F, 1'b0);
    st = status();
    checks++;
    if (st !== 5'b00010 || ifc.arb_rsp_paddr !== 28'h000030F) begin
      errors++;
      $display("FAIL flush_next_rsp got %b/%h exp %b/%h", st, ifc.arb_rsp_paddr, 5'b00010, 28'h000030F);
    end
  endtask

  task automatic test_flush_p();
    logic [4:0] st;
    drive(1'b0, 28'h0, 1'b1, 28'h0000040, 1'b1, 28'h0, 1'b1);
    st = status();
    checks++;
    if (st !== 5'b10100 || ifc.arb2ic_vaddr !== 28'h0000040) begin
      errors++;
      $display("FAIL p_grant got %b/%h exp %b/%h", st, ifc.arb2ic_vaddr, 5'b10100, 28'h0000040);
    end
    drive(1'b0, 28'h0, 1'b0, 28'h0, 1'b0, 28'h0, 1'b1);
    st = status();
    checks++;
    if (st !== 5'b00000) begin
      errors++;
      $display("FAIL p_wait got %b exp %b", st, 5'b00000);
    end
    drive(1'b0, 28'h0, 1'b0, 28'h0, 1'b1, 28'h0004444, 1'b1);
    st = status();
    checks++;
    if (st !== 5'b00001 || ifc.arb_rsp_paddr !== 28'h0004444) begin
      errors++;
      $display("FAIL p_rsp_flush got %b/%h exp %b/%h", st, ifc.arb_rsp_paddr, 5'b00001, 28'h0004444);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] st;
    drive(1'b1, 28'h0000050, 1'b0, 28'h0, 1'b1, 28'h0, 1'b0);
    st = status();
    checks++;
    if (st !== 5'b11000) begin
      errors++;
      $display("FAIL b2b_f_grant got %b exp %b", st, 5'b11000);
    end
    drive(1'b0, 28'h0, 1'b1, 28'h0000060, 1'b1, 28'h0005050, 1'b0);
    st = status();
    checks++;
    if (st !== 5'b10110 || ifc.arb_rsp_paddr !== 28'h0005050) begin
      errors++;
      $display("FAIL b2b_swap got %b/%h exp %b/%h", st, ifc.arb_rsp_paddr, 5'b10110, 28'h0005050);
    end
    drive(1'b0, 28'h0, 1'b0, 28'h0, 1'b1, 28'h0006060, 1'b0);
    st = status();
    checks++;
    if (st !== 5'b00001 || ifc.arb_rsp_paddr !== 28'h0006060) begin
      errors++;
      $display("FAIL b2b_p_rsp got %b/%h exp %b/%h", st, ifc.arb_rsp_paddr, 5'b00001, 28'h0006060);
    end
  endtask

  task automatic test_flush_with_grant();
    logic [4:0] st;
    drive(1'b1, 28'h0000080, 1'b0, 28'h0, 1'b1, 28'h0, 1'b0);
    drive(1'b1, 28'h0000090, 1'b0, 28'h0, 1'b1, 28'h0008080, 1'b1);
    st = status();
    checks++;
    if (st !== 5'b11000) begin
      errors++;
      $display("FAIL flushgnt_kill got %b exp %b", st, 5'b11000);
    end
    drive(1'b0, 28'h0, 1'b0, 28'h0, 1'b1, 28'h0009090, 1'b0);
    st = status();
    checks++;
    if (st !== 5'b00010 || ifc.arb_rsp_paddr !== 28'h0009090) begin
      errors++;
      $display("FAIL flushgnt_new got %b/%h exp %b/%h", st, ifc.arb_rsp_paddr, 5'b00010, 28'h0009090);
    end
  endtask

  task automatic test_reset_midflight();
    logic [4:0] st;
    drive(1'b1, 28'h0000070, 1'b0, 28'h0, 1'b1, 28'h0, 1'b0);
    drive(1'b0, 28'h0, 1'b0, 28'h0, 1'b0, 28'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst_n = 1'b0;
      ifc.f2arb_valid  = 1'b1;
      ifc.f2arb_vaddr  = 28'h0000071;
      ifc.p2arb_valid  = 1'b1;
      ifc.p2arb_vaddr  = 28'h0000072;
      ifc.ic2arb_ready = 1'b1;
      ifc.ic2arb_paddr = 28'h0007070;
      #1;
      st = status();
      checks++;
      if (st !== 5'b00000 || ifc.arb2ic_vaddr !== 28'h0 || ifc.arb_rsp_paddr !== 28'h0) begin
        errors++;
        $display("FAIL midrst_outputs[%0d] got %b/%h/%h exp 00000/0/0", i, st,
                 ifc.arb2ic_vaddr, ifc.arb_rsp_paddr);
      end
    end
    drive(1'b0, 28'h0, 1'b0, 28'h0, 1'b0, 28'h0, 1'b0);
    rst_n = 1'b1;
    drive(1'b0, 28'h0, 1'b0, 28'h0, 1'b1, 28'h0007777, 1'b0);
    st = status();
    checks++;
    if (st !== 5'b00000) begin
      errors++;
      $display("FAIL midrst_stale got %b exp %b", st, 5'b00000);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    ifc.f2arb_valid  = 1'b0;
    ifc.f2arb_vaddr  = '0;
    ifc.p2arb_valid  = 1'b0;
    ifc.p2arb_vaddr  = '0;
    ifc.ic2arb_ready = 1'b0;
    ifc.ic2arb_paddr = '0;
    ifc.pipe_flush   = 1'b0;
    test_reset();
    test_fetch_only();
    test_starvation();
    test_flush_drop();
    test_flush_p();
    test_back_to_back();
    test_flush_with_grant();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcpu_core_icache_arb.md
Name: mcpu_core_icache_arb

Overview:
- Two-requester arbiter/scheduler for the single I$ lookup port.
- Shares the port between the fetch stage (requester F, high priority) and a secondary requester (requester P: prefetcher/debug instruction reads).
- Sits between the fetch stage and the I$ and routes each I$ response back to the requester that owns it.
- Tracks the one in-flight lookup, bounds P starvation with a counter, and discards fetch responses killed by a pipeline flush.

Parameters:
- STARVE_MAX, 8: consecutive denied-P cycles after which P gets priority for one grant (legal 1..15).
- CNT_W, 4: starvation counter width; must hold STARVE_MAX.

Ports:
- clkrst_core_clk  in  1  core clock
- clkrst_core_rst_n  in  1  asynchronous active-low reset
- f2arb_vaddr  in  28  fetch request address
- f2arb_valid  in  1  fetch request valid
- arb2f_gnt  out  1  fetch request accepted this cycle
- arb2f_rsp_valid  out  1  fetch response valid this cycle
- p2arb_vaddr  in  28  secondary request address
- p2arb_valid  in  1  secondary request valid
- arb2p_gnt  out  1  secondary request accepted this cycle
- arb2p_rsp_valid  out  1  secondary response valid this cycle
- arb_rsp_paddr  out  28  translated address of the current response (broadcast to both requesters)
- pipe_flush  in  1  pipeline flush; cancels the in-flight fetch response
- arb2ic_vaddr  out  28  address to I$
- arb2ic_valid  out  1  request to I$
- ic2arb_ready  in  1  I$ accepts a request this cycle and completes the previous one
- ic2arb_paddr  in  28  translated address of the completing lookup

Behaviour:
- Reset: clock is clkrst_core_clk; reset is clkrst_core_rst_n, asynchronous, active-low.
  - Reset clears: inflight=0, owner=F, drop=0, starve_cnt=0, p_prio=0.
  - All outputs are 0 while reset is asserted, including arb2ic_valid.
- I$ protocol: a lookup accepted when arb2ic_valid & ic2arb_ready in cycle N completes in the next cycle M>N with ic2arb_ready=1. At most one lookup is in flight.
- Selection, combinational each cycle:
  - If p_prio=1 and p2arb_valid, select P.
  - Otherwise, if f2arb_valid, select F.
  - Otherwise, if p2arb_valid, select P.
- Request outputs:
  - arb2ic_valid = f2arb_valid | p2arb_valid.
  - arb2ic_vaddr = address of the selected requester.
  - gnt_X = (selected==X) & ic2arb_ready. At most one gnt is high.
- On acceptance: inflight<=1, owner<=selected, drop<=0.
- On ic2arb_ready with no request: inflight<=0.
- Response:
  - rsp_X = inflight & ic2arb_ready & owner==X & !(owner==F & (drop | pipe_flush)).
  - arb_rsp_paddr = ic2arb_paddr, passed through combinationally. Latency from grant to response is at least 1 cycle.
- Flush:
  - pipe_flush while inflight & owner==F & !ic2arb_ready sets drop<=1; the later completion raises no rsp.
  - pipe_flush never affects P responses or P grants.
  - A fetch grant in the flush cycle is honoured and belongs to the new stream.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) each cycle p2arb_valid & !arb2p_gnt.
  - Clears on arb2p_gnt or !p2arb_valid.
  - When starve_cnt reaches STARVE_MAX, p_prio<=1. p_prio clears on arb2p_gnt.
- Simultaneous completion and new grant: the response goes to the old owner and owner updates to the new one in the same edge.
- Reset mid-lookup: state is cleared and the stale completion is ignored because inflight=0.

Decomposition:
- Shared core package holds:
  - Requester ID constants (ARB_ID_F=0, ARB_ID_P=1).
  - The 28-bit virtual/physical address width constant used by fetch and I$.
- One natural sub-module, mcpu_core_arb_starve: the saturating starvation counter plus p_prio flag. Everything else stays inline.

Test Plan:
- Fetch only, ready stuck 1, vaddr 0x0000010,0x0000011,0x0000012 -> gnt_F every cycle; rsp_F starts cycle+1 with paddr echoed; arb2p_* stay 0.
- F and P both valid continuously, STARVE_MAX=8 -> F granted 8 cycles, P granted on cycle 9 (vaddr=P addr), F resumes cycle 10; pattern repeats every 9 grants.
- Fetch granted, ic2arb_ready low 3 cycles, pipe_flush pulsed cycle 1 -> completion cycle raises neither rsp_F nor rsp_P; next fetch grant responds normally.
- P granted, pipe_flush during its in-flight cycle -> rsp_P still asserted on completion with correct paddr.
- Completion coincident with a new P grant after an F lookup -> rsp_F=1 that cycle, rsp_P=1 on next ready.
- Assert rst_n low while inflight with ready=0, release, drive ready=1 with no requests -> no rsp; all outputs 0 during reset.
